// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply sequencer.
//   - mul_op_e : funct3[1:0] encodings of the four multiply ops
//   - state_e  : sequencer states
//   - sizing constants for the radix-4 Booth datapath
package rv32m_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PROD_W = 64;
  // 34-bit extended multiplier plus the implicit m[-1] bit at position 0
  localparam int unsigned MEXT_W = 35;
  localparam int unsigned NUM_PP = 17;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/rv32m_booth_digit.sv
// Radix-4 Booth partial-product generator (combinational).
//   triplet_i : {m[2i+1], m[2i], m[2i-1]}
//   x_i       : 64-bit extended multiplicand
//   idx_i     : digit index i (0..16)
//   pp_c      : digit_i * X << 2i, mod 2^64
module rv32m_booth_digit
  import rv32m_pkg::*;
(
  input  logic [2:0]        triplet_i,
  input  logic [PROD_W-1:0] x_i,
  input  logic [4:0]        idx_i,
  output logic [PROD_W-1:0] pp_c
);

  logic [PROD_W-1:0] mag;
  logic              neg;
  logic [PROD_W-1:0] sgn_mag;

  // Booth recoding: magnitude selection and sign
  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (triplet_i)
      3'b001, 3'b010: mag = x_i;
      3'b011:         mag = x_i << 1;
      3'b100: begin
        mag = x_i << 1;
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = x_i;
        neg = 1'b1;
      end
      default:        mag = '0;
    endcase
    sgn_mag = neg ? (~mag + PROD_W'(1)) : mag;
    pp_c    = sgn_mag << {idx_i, 1'b0};
  end

endmodule

// File: rtl/rv32m_mul_seq.sv
// Multi-cycle RV32M multiply sequencer (MUL/MULH/MULHSU/MULHU).
// Accepts an op over in_valid/in_ready, accumulates PP_PER_CYCLE Booth
// partial products per CALC cycle into a 64-bit accumulator, and returns
// the selected product half with its tag over out_valid/out_ready.
//   in_*  : request channel (op, rs1 multiplicand, rs2 multiplier, tag)
//   out_* : result channel (32-bit result, tag)
//   busy  : state != IDLE
//   flush : kills any in-flight op and blocks a same-cycle accept
module rv32m_mul_seq
  import rv32m_pkg::*;
#(
  parameter int unsigned PP_PER_CYCLE = 4,
  parameter int unsigned TAG_W        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  input  logic             flush
);

  localparam int unsigned CNT_W = 6;

  state_e              state_q, state_d;
  mul_op_e             op_q, op_d;
  logic [PROD_W-1:0]   x_q, x_d;
  logic [MEXT_W-1:0]   m_q, m_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     out_result_q, out_result_d;
  logic [TAG_W-1:0]    out_tag_q, out_tag_d;

  logic [PROD_W-1:0]   pp_c [PP_PER_CYCLE];
  logic [PROD_W-1:0]   pp_sum_c;
  logic [PROD_W-1:0]   acc_sum_c;
  logic                last_c;
  logic                rs1_signed_c;
  logic                rs2_signed_c;

  // One Booth lane per partial product handled this cycle; lanes past
  // digit 16 contribute zero.
  for (genvar g = 0; g < PP_PER_CYCLE; g++) begin : g_pp
    logic [CNT_W-1:0]  idx;
    logic              in_range;
    logic [4:0]        idx_sel;
    logic [2:0]        triplet;
    logic [PROD_W-1:0] pp_raw;

    assign idx      = cnt_q + CNT_W'(g);
    assign in_range = (idx < CNT_W'(NUM_PP));
    assign idx_sel  = in_range ? idx[4:0] : 5'd0;
    assign triplet  = 3'(m_q >> {idx_sel, 1'b0});

    rv32m_booth_digit u_digit (
      .triplet_i (triplet),
      .x_i       (x_q),
      .idx_i     (idx_sel),
      .pp_c      (pp_raw)
    );

    assign pp_c[g] = in_range ? pp_raw : '0;
  end

  // Sum of this cycle's partial products, added onto the accumulator
  always_comb begin
    pp_sum_c = '0;
    for (int unsigned k = 0; k < PP_PER_CYCLE; k++) begin
      pp_sum_c = pp_sum_c + pp_c[k];
    end
    acc_sum_c = acc_q + pp_sum_c;
    last_c    = ((cnt_q + CNT_W'(PP_PER_CYCLE)) >= CNT_W'(NUM_PP));
  end

  assign rs1_signed_c = (in_op == OP_MULH) || (in_op == OP_MULHSU);
  assign rs2_signed_c = (in_op == OP_MULH);

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    x_d          = x_q;
    m_d          = m_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;

    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d      = mul_op_e'(in_op);
          x_d       = {{XLEN{rs1_signed_c & in_rs1[XLEN-1]}}, in_rs1};
          m_d       = {{2{rs2_signed_c & in_rs2[XLEN-1]}}, in_rs2, 1'b0};
          acc_d     = '0;
          cnt_d     = '0;
          out_tag_d = in_tag;
          // A zero operand skips the Booth passes entirely
          if ((in_rs1 == '0) || (in_rs2 == '0)) begin
            state_d      = DONE;
            out_valid_d  = 1'b1;
            out_result_d = '0;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          acc_d = acc_sum_c;
          cnt_d = cnt_q + CNT_W'(PP_PER_CYCLE);
          if (last_c) begin
            state_d      = DONE;
            out_valid_d  = 1'b1;
            out_result_d = (op_q == OP_MUL) ? acc_sum_c[XLEN-1:0]
                                            : acc_sum_c[PROD_W-1:XLEN];
          end
        end
      end
      DONE: begin
        if (flush || out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= OP_MUL;
      x_q          <= '0;
      m_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      x_q          <= x_d;
      m_q          <= m_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_rv32m_mul_seq.sv
// Directed bench for rv32m_mul_seq. The default-parameter instance is the
// main target; PP_PER_CYCLE=1 and =17 instances share its inputs and are
// exercised by the latency and regression scenarios after a reset resync.
module tb_rv32m_mul_seq;
  import rv32m_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [4:0]  in_tag = '0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;

  logic        in_ready, out_valid, busy;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        in_ready_p1, out_valid_p1, busy_p1;
  logic [31:0] out_result_p1;
  logic [4:0]  out_tag_p1;
  logic        in_ready_p17, out_valid_p17, busy_p17;
  logic [31:0] out_result_p17;
  logic [4:0]  out_tag_p17;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv32m_mul_seq #(.PP_PER_CYCLE(4), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy), .flush(flush));

  rv32m_mul_seq #(.PP_PER_CYCLE(1), .TAG_W(5)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_p1),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid_p1), .out_ready(out_ready), .out_result(out_result_p1),
    .out_tag(out_tag_p1), .busy(busy_p1), .flush(flush));

  rv32m_mul_seq #(.PP_PER_CYCLE(17), .TAG_W(5)) dut_p17 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_p17),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid_p17), .out_ready(out_ready), .out_result(out_result_p17),
    .out_tag(out_tag_p17), .busy(busy_p17), .flush(flush));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_rs1   = a;
    in_rs2   = b;
    in_tag   = tag;
    step();
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid of the main instance
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       output logic [31:0] res, output logic [4:0] t,
                       output int lat);
    out_ready = 1'b0;
    issue(op, a, b, tag);
    wait_valid(lat);
    res = out_result;
    t   = out_tag;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #21;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", out_result); end
    n_tests++; if (out_tag !== 5'h0) begin n_fail++; $display("FAIL reset_tag got %h want 0", out_tag); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mul_basic();
    int lat;
    out_ready = 1'b1;
    issue(2'(OP_MUL), 32'd7, 32'hFFFF_FFFD, 5'd5);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
    wait_valid(lat);
    n_tests++; if (lat != 5) begin n_fail++; $display("FAIL basic_latency got %0d want 5", lat); end
    n_tests++; if (out_result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL basic_result got %h want ffffffeb", out_result); end
    n_tests++; if (out_tag !== 5'd5) begin n_fail++; $display("FAIL basic_tag got %0d want 5", out_tag); end
    step();
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_handshake got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    out_ready = 1'b0;
  endtask

  localparam logic [1:0]  SV_OP [7] = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10};
  localparam logic [31:0] SV_A  [7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                        32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
  localparam logic [31:0] SV_B  [7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                        32'h0000_0010, 32'h0000_0002, 32'h0000_0002};
  localparam logic [31:0] SV_R  [7] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000,
                                        32'h2345_6780, 32'h0000_0001, 32'hFFFF_FFFF};

  task automatic test_signed();
    logic [31:0] res;
    logic [4:0]  t;
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(SV_OP[i], SV_A[i], SV_B[i], 5'(i + 10), res, t, lat);
      n_tests++;
      if (res !== SV_R[i] || t !== 5'(i + 10) || lat != 5) begin
        n_fail++;
        $display("FAIL signed_vec%0d got res=%h tag=%0d lat=%0d want res=%h tag=%0d lat=5",
                 i, res, t, lat, SV_R[i], i + 10);
      end
    end
  endtask

  task automatic test_zero_fast();
    logic [31:0] res;
    logic [4:0]  t;
    int lat;
    out_ready = 1'b0;
    issue(2'(OP_MULHU), 32'h0, 32'h1234_5678, 5'd3);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid_after_1 got %b want 1", out_valid); end
    n_tests++; if (out_result !== 32'h0 || out_tag !== 5'd3) begin n_fail++; $display("FAIL zero_result got %h/%0d want 0/3", out_result, out_tag); end
    n_tests++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy got ready=%b busy=%b want 0/1", in_ready, busy); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_return_idle got %b want 1", in_ready); end
    do_op(2'(OP_MUL), 32'hDEAD_BEEF, 32'h0, 5'd4, res, t, lat);
    n_tests++; if (res !== 32'h0 || lat != 0) begin n_fail++; $display("FAIL zero_rs2 got res=%h lat=%0d want 0/0", res, lat); end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    out_ready = 1'b0;
    issue(2'(OP_MUL), 32'd6, 32'd7, 5'd9);
    wait_valid(lat);
    in_rs1 = 32'h5555_5555;
    in_rs2 = 32'hAAAA_AAAA;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_tests++;
      if (out_valid !== 1'b1 || out_result !== 32'd42 || out_tag !== 5'd9 || in_ready !== 1'b0) begin
        n_fail++; bad++;
        $display("FAIL bp_hold cycle %0d got v=%b r=%h t=%0d rdy=%b want 1/2a/9/0",
                 i, out_valid, out_result, out_tag, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got v=%b rdy=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    logic [4:0]  t;
    int lat;
    int seen = 0;
    out_ready = 1'b1;
    issue(2'(OP_MUL), 32'd100, 32'd200, 5'd1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_tests++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_calc got rdy=%b busy=%b v=%b want 1/0/0", in_ready, busy, out_valid); end
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL flush_calc_no_result got %0d valid cycles want 0", seen); end
    out_ready = 1'b0;
    issue(2'(OP_MULHU), 32'd3, 32'd3, 5'd2);
    wait_valid(lat);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_done got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    flush = 1'b1;
    issue(2'(OP_MUL), 32'd9, 32'd9, 5'd6);
    flush = 1'b0;
    n_tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_accept got busy=%b rdy=%b want 0/1", busy, in_ready); end
    do_op(2'(OP_MUL), 32'd3, 32'd5, 5'd7, res, t, lat);
    n_tests++; if (res !== 32'd15 || t !== 5'd7) begin n_fail++; $display("FAIL flush_then_mul got %0d/%0d want 15/7", res, t); end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    logic [4:0]  t;
    int lat;
    out_ready = 1'b0;
    issue(2'(OP_MUL), 32'd123, 32'd456, 5'd4);
    step();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'h0 || out_tag !== 5'h0) begin
      n_fail++;
      $display("FAIL async_reset got rdy=%b busy=%b v=%b r=%h t=%0d want 1/0/0/0/0",
               in_ready, busy, out_valid, out_result, out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_op(2'(OP_MUL), 32'd2, 32'd3, 5'd8, res, t, lat);
    n_tests++; if (res !== 32'd6 || lat != 5) begin n_fail++; $display("FAIL post_reset_op got %0d lat=%0d want 6 lat=5", res, lat); end
  endtask

  task automatic test_param_latency();
    int l4 = -1;
    int l1 = -1;
    int l17 = -1;
    sync_reset();
    out_ready = 1'b0;
    issue(2'(OP_MUL), 32'd7, 32'hFFFF_FFFD, 5'd1);
    for (int c = 1; c <= 30; c++) begin
      step();
      if (out_valid === 1'b1 && l4 < 0) l4 = c;
      if (out_valid_p1 === 1'b1 && l1 < 0) l1 = c;
      if (out_valid_p17 === 1'b1 && l17 < 0) l17 = c;
    end
    n_tests++; if (l4 != 5 || l1 != 17 || l17 != 1) begin n_fail++; $display("FAIL param_latency got %0d/%0d/%0d want 5/17/1", l4, l1, l17); end
    n_tests++; if (out_result_p1 !== 32'hFFFF_FFEB || out_result_p17 !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL param_result got %h/%h want ffffffeb", out_result_p1, out_result_p17); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand(input int sel);
    case (sel)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_regression();
    logic [1:0]  op;
    logic [31:0] a, b, exp;
    logic [63:0] ax, bx, prod;
    int cyc;
    sync_reset();
    for (int n = 0; n < 300; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand($urandom_range(0, 12));
      b  = pick_operand($urandom_range(0, 12));
      ax = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
      bx = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
      prod = ax * bx;
      exp  = (op == 2'b00) ? prod[31:0] : prod[63:32];
      cyc = 0;
      while (!(in_ready && in_ready_p1 && in_ready_p17) && cyc < 40) begin step(); cyc++; end
      out_ready = 1'b0;
      issue(op, a, b, 5'(n));
      cyc = 0;
      while (!(out_valid && out_valid_p1 && out_valid_p17) && cyc < 40) begin step(); cyc++; end
      n_tests++; if (out_result !== exp) begin n_fail++; $display("FAIL regr_pp4 #%0d op=%0d a=%h b=%h got %h want %h", n, op, a, b, out_result, exp); end
      n_tests++; if (out_result_p1 !== exp) begin n_fail++; $display("FAIL regr_pp1 #%0d op=%0d a=%h b=%h got %h want %h", n, op, a, b, out_result_p1, exp); end
      n_tests++; if (out_result_p17 !== exp) begin n_fail++; $display("FAIL regr_pp17 #%0d op=%0d a=%h b=%h got %h want %h", n, op, a, b, out_result_p17, exp); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_signed();
    test_zero_fast();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_param_latency();
    test_regression();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
